// File: rtl/uts_pkg.sv
// Shared types and constants for the RMU serial-link deserialiser.
package uts_pkg;

  typedef enum logic [1:0] {
    UTS_IDLE  = 2'd0,
    UTS_SHIFT = 2'd1,
    UTS_HOLD  = 2'd2
  } uts_state_e;

  localparam int unsigned UTS_FCNT_W = 16;
  localparam int unsigned UTS_DATA_W = 8;

endpackage

// File: rtl/uts_deser.sv
// Serial-to-parallel receiver for the RMU address/data link: assembles DATA_W strobed bits
// per ale frame, with frame counting and short/overrun frame error flags.
module uts_deser
  import uts_pkg::*;
#(
  parameter int unsigned DATA_W    = UTS_DATA_W,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          HOLD_DATA = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ale,
  input  logic                  rmuadd,
  input  logic                  ps1,
  output logic [DATA_W-1:0]     rmudata,
  output logic                  rmuvalid,
  output logic                  busy,
  output logic                  short_err,
  output logic                  ovr_err,
  output logic [UTS_FCNT_W-1:0] frame_cnt
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W - 1);

  uts_state_e            state_q, state_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [DATA_W-1:0]     shifted;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  short_q, short_d;
  logic                  ovr_q, ovr_d;
  logic [UTS_FCNT_W-1:0] fcnt_q, fcnt_d;

  // After DATA_W shifts every stale bit has been pushed out, so no clear is needed at frame start.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[DATA_W-2:0], rmuadd};
    end else begin : g_lsb_first
      assign shifted = {rmuadd, shreg_q[DATA_W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    short_d = 1'b0;
    ovr_d   = ovr_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      UTS_IDLE: begin
        if (ale) begin
          state_d = UTS_SHIFT;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          if (!HOLD_DATA) begin
            data_d = '0;
          end
          if (ps1) begin
            shreg_d = shifted;
            cnt_d   = CntW'(1);
          end
        end
      end

      UTS_SHIFT: begin
        if (!ale) begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = UTS_IDLE;
        end else if (ps1) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastIdx) begin
            data_d  = shifted;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + UTS_FCNT_W'(1);
            state_d = UTS_HOLD;
          end
        end
      end

      UTS_HOLD: begin
        if (!ale) begin
          state_d = UTS_IDLE;
        end else if (ps1) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_d = UTS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= UTS_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      short_q <= short_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rmudata   = data_q;
  assign rmuvalid  = valid_q;
  assign busy      = (state_q == UTS_SHIFT);
  assign short_err = short_q;
  assign ovr_err   = ovr_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_uts_deser.sv
// Bench for uts_deser: three variants (MSB-first, LSB-first, clear-on-start) share one stimulus
// stream and are compared every cycle against a frame-level model, plus directed literal checks.
module tb_uts_deser;
  import uts_pkg::*;

  localparam int W    = int'(UTS_DATA_W);
  localparam int NDut = 3;

  logic clk = 1'b0;
  logic reset, ale, rmuadd, ps1;

  logic [W-1:0]  d_data  [NDut];
  logic          d_valid [NDut];
  logic          d_busy  [NDut];
  logic          d_short [NDut];
  logic          d_ovr   [NDut];
  logic [15:0]   d_fcnt  [NDut];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // dut 0: MSB first, hold; dut 1: LSB first, hold; dut 2: MSB first, clear on frame start
  for (genvar g = 0; g < NDut; g++) begin : g_dut
    uts_deser #(
      .DATA_W   (W),
      .MSB_FIRST((g == 1) ? 1'b0 : 1'b1),
      .HOLD_DATA((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .ale      (ale),
      .rmuadd   (rmuadd),
      .ps1      (ps1),
      .rmudata  (d_data[g]),
      .rmuvalid (d_valid[g]),
      .busy     (d_busy[g]),
      .short_err(d_short[g]),
      .ovr_err  (d_ovr[g]),
      .frame_cnt(d_fcnt[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame opens on ale high, collects strobed bits, closes on ale low.
  bit           fq[$];
  bit           m_open = 1'b0;
  bit           m_live = 1'b0;
  logic [W-1:0] m_data [NDut];
  logic         m_valid, m_short, m_ovr;
  logic [15:0]  m_fcnt;

  function automatic logic [W-1:0] assemble(input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = fq[i];
      else           w[i]     = fq[i];
    end
    return w;
  endfunction

  task automatic model_step();
    if (!reset) begin
      fq.delete();
      m_open  = 1'b0;
      for (int k = 0; k < NDut; k++) m_data[k] = '0;
      m_valid = 1'b0;
      m_short = 1'b0;
      m_ovr   = 1'b0;
      m_fcnt  = '0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_valid = 1'b0;
      m_short = 1'b0;
      if (!m_open) begin
        if (ale) begin
          m_open = 1'b1;
          fq.delete();
          m_ovr = 1'b0;
          m_data[2] = '0;
          if (ps1) fq.push_back(rmuadd);
        end
      end else if (!ale) begin
        if (fq.size() < W) m_short = 1'b1;
        m_open = 1'b0;
      end else if (ps1) begin
        if (fq.size() < W) begin
          fq.push_back(rmuadd);
          if (fq.size() == W) begin
            for (int k = 0; k < NDut; k++) m_data[k] = assemble(k != 1);
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 16'd1;
          end
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_live) begin
        for (int k = 0; k < NDut; k++) begin
          chk($sformatf("cyc.d%0d.rmudata", k), 32'(d_data[k]), 32'(m_data[k]));
          chk($sformatf("cyc.d%0d.rmuvalid", k), 32'(d_valid[k]), 32'(m_valid));
          chk($sformatf("cyc.d%0d.busy", k), 32'(d_busy[k]),
              32'(m_open && (fq.size() < W)));
          chk($sformatf("cyc.d%0d.short_err", k), 32'(d_short[k]), 32'(m_short));
          chk($sformatf("cyc.d%0d.ovr_err", k), 32'(d_ovr[k]), 32'(m_ovr));
          chk($sformatf("cyc.d%0d.frame_cnt", k), 32'(d_fcnt[k]), 32'(m_fcnt));
        end
      end
    end
  end

  task automatic cyc(input logic a, input logic p, input logic d);
    ale    = a;
    ps1    = p;
    rmuadd = d;
    @(posedge clk);
    #1;
  endtask

  // Sends n bits, v[n-1] first, one strobe every second cycle; returns right after the last strobe.
  task automatic send(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, v[n-1-i]);
    end
  endtask

  initial begin
    logic a_n;
    reset  = 1'b0;
    ale    = 1'b0;
    ps1    = 1'b0;
    rmuadd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.rmudata", 32'(d_data[0]), 32'h0);
    chk("rst.frame_cnt", 32'(d_fcnt[0]), 32'h0);
    chk("rst.busy", 32'(d_busy[0]), 32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // 1,0,1,0,0,1,0,1 is a palindrome: both bit orders give A5
    send(32'hA5, 8);
    chk("a5.valid_latency", 32'(d_valid[0]), 32'h1);
    chk("a5.msb_data", 32'(d_data[0]), 32'hA5);
    chk("a5.lsb_data", 32'(d_data[1]), 32'hA5);
    chk("a5.frame_cnt", 32'(d_fcnt[0]), 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("a5.valid_one_cycle", 32'(d_valid[0]), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    send(32'h15, 5);
    cyc(1'b0, 1'b0, 1'b0);
    chk("short.pulse", 32'(d_short[0]), 32'h1);
    chk("short.no_valid", 32'(d_valid[0]), 32'h0);
    chk("short.data_held", 32'(d_data[0]), 32'hA5);
    chk("short.clear_variant", 32'(d_data[2]), 32'h0);
    chk("short.frame_cnt", 32'(d_fcnt[0]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("short.one_cycle", 32'(d_short[0]), 32'h0);

    send(32'h80, 8);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("seq80.msb_data", 32'(d_data[0]), 32'h80);
    chk("seq80.lsb_data", 32'(d_data[1]), 32'h01);
    chk("seq80.frame_cnt", 32'(d_fcnt[0]), 32'h2);

    send(32'h3C, 8);
    chk("ovr.data", 32'(d_data[0]), 32'h3C);
    chk("ovr.before_extra", 32'(d_ovr[0]), 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("ovr.rise_9th", 32'(d_ovr[0]), 32'h1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ovr.sticky", 32'(d_ovr[0]), 32'h1);
    chk("ovr.data_kept", 32'(d_data[0]), 32'h3C);
    chk("ovr.frame_cnt", 32'(d_fcnt[0]), 32'h3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("ovr.cleared_on_start", 32'(d_ovr[0]), 32'h0);
    chk("ovr.busy_on_start", 32'(d_busy[0]), 32'h1);

    // ale drops straight after the last strobe, then one low cycle before the next frame
    send(32'h5A, 8);
    chk("edge.valid", 32'(d_valid[0]), 32'h1);
    chk("edge.data", 32'(d_data[0]), 32'h5A);
    cyc(1'b0, 1'b0, 1'b0);
    chk("edge.no_short", 32'(d_short[0]), 32'h0);
    chk("edge.idle", 32'(d_busy[0]), 32'h0);
    send(32'hC3, 8);
    chk("b2b.data", 32'(d_data[0]), 32'hC3);
    chk("b2b.frame_cnt", 32'(d_fcnt[0]), 32'h5);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    send(32'hF, 4);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst.rmudata", 32'(d_data[0]), 32'h0);
    chk("midrst.busy", 32'(d_busy[0]), 32'h0);
    chk("midrst.frame_cnt", 32'(d_fcnt[0]), 32'h0);
    chk("midrst.short", 32'(d_short[0]), 32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst.no_late_short", 32'(d_short[0]), 32'h0);
    send(32'hFF, 8);
    chk("midrst.ff_data", 32'(d_data[0]), 32'hFF);
    chk("midrst.ff_count", 32'(d_fcnt[0]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // randomized traffic: long ale windows, dense strobes, occasional reset
    a_n = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) != 0);
      if (a_n) a_n = ($urandom_range(0, 24) != 0);
      else     a_n = ($urandom_range(0, 3) == 0);
      cyc(a_n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    reset = 1'b1;
    for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
